// File: rtl/granule_assembler_pp.sv
// Double-buffered granule/channel assembler. Position-addressed samples are
// written into one bank while the other streams out one granule-position per
// beat with all channels side by side. Drained locations are zero-flushed so
// that every bank starts a new frame all-zero.
module granule_assembler_pp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 576,
  parameter int NUM_GR = 2,
  parameter int NUM_CH = 2,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int SLOT_W = $clog2(NUM_GR*NUM_CH),
  parameter int GR_W   = (NUM_GR > 1) ? $clog2(NUM_GR) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [SLOT_W-1:0]        wr_slot,
  input  logic [ADDR_W-1:0]        wr_pos,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_frame_end,
  input  logic [1:0]               wr_nch,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [GR_W-1:0]          rd_gr,
  output logic [ADDR_W-1:0]        rd_idx,
  output logic                     rd_last,
  output logic                     init_busy,
  output logic                     err_drop,
  output logic                     err_range
);

  localparam int NSLOT  = NUM_GR*NUM_CH;
  localparam int NRAM   = 2*NSLOT;
  localparam int RAM_W  = $clog2(NRAM);
  localparam int CH_W   = $clog2(NUM_CH+1);
  localparam int BEAT_W = 1 + GR_W + ADDR_W + NUM_CH*DATA_W;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
  typedef enum logic [1:0] {I_START, I_SWEEP, I_DONE} init_t;

  logic [DATA_W-1:0] mem [NRAM][DEPTH];

  init_t              init_st, init_nx;
  logic [ADDR_W-1:0]  init_addr, init_addr_nx;
  bank_t              bank_st [2];
  bank_t              bank_nx [2];
  logic               wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [CH_W-1:0]    nch_q [2];
  logic [CH_W-1:0]    nch_in;
  logic [GR_W-1:0]    gr_c;
  logic [ADDR_W-1:0]  idx_c;
  logic               iss_done;
  logic               issue, iss_last, start_drain, pop, head_last;
  logic               range_bad, wr_acc, fe_acc;
  logic [NUM_CH-1:0]  lane_en;
  logic [RAM_W-1:0]   wr_ram, rd_base;
  logic               v1, v2, last1, last2;
  logic [GR_W-1:0]    gr1, gr2;
  logic [ADDR_W-1:0]  idx1, idx2;
  logic [NUM_CH*DATA_W-1:0] d1, d2;
  logic [BEAT_W-1:0]  fifo [4];
  logic [1:0]         f_wp, f_rp;
  logic [2:0]         f_cnt;

  // State registers: init sequencer, bank states, pointers, per-bank channel count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_st    <= I_START;
      init_addr  <= '0;
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      nch_q[0]   <= '0;
      nch_q[1]   <= '0;
    end else begin
      init_st    <= init_nx;
      init_addr  <= init_addr_nx;
      bank_st[0] <= bank_nx[0];
      bank_st[1] <= bank_nx[1];
      wr_ptr     <= wr_ptr_nx;
      rd_ptr     <= rd_ptr_nx;
      if (fe_acc) nch_q[wr_ptr] <= nch_in;
    end
  end

  // Next-state logic: init sweep progress and the fill/drain bank life cycle
  always_comb begin
    init_nx      = init_st;
    init_addr_nx = init_addr;
    case (init_st)
      I_START: begin
        init_nx      = I_SWEEP;
        init_addr_nx = '0;
      end
      I_SWEEP: begin
        if (init_addr == ADDR_W'(DEPTH-1)) init_nx = I_DONE;
        else init_addr_nx = init_addr + ADDR_W'(1);
      end
      default: ;
    endcase

    bank_nx[0]  = bank_st[0];
    bank_nx[1]  = bank_st[1];
    wr_ptr_nx   = wr_ptr;
    rd_ptr_nx   = rd_ptr;
    start_drain = 1'b0;
    if (fe_acc) begin
      bank_nx[wr_ptr] = B_FULL;
      wr_ptr_nx       = ~wr_ptr;
    end else if (wr_acc && bank_st[wr_ptr] == B_EMPTY) begin
      bank_nx[wr_ptr] = B_FILLING;
    end
    // A waiting full bank is promoted straight to draining when the current one
    // finishes, so issue resumes on the very next cycle.
    if (pop && head_last) begin
      bank_nx[rd_ptr] = B_EMPTY;
      rd_ptr_nx       = ~rd_ptr;
      if (bank_st[~rd_ptr] == B_FULL) begin
        bank_nx[~rd_ptr] = B_DRAINING;
        start_drain      = 1'b1;
      end
    end else if (bank_st[rd_ptr] == B_FULL) begin
      bank_nx[rd_ptr] = B_DRAINING;
      start_drain     = 1'b1;
    end
  end

  // Output/control decode: handshakes, write legality, read issue with credit
  always_comb begin
    init_busy = (init_st == I_SWEEP);
    wr_ready  = (init_st == I_DONE) &&
                (bank_st[wr_ptr] == B_EMPTY || bank_st[wr_ptr] == B_FILLING);
    range_bad = (32'(wr_pos) >= DEPTH) || (32'(wr_slot) >= NSLOT);
    wr_acc    = wr_valid && wr_ready && !range_bad;
    fe_acc    = wr_frame_end && wr_ready;
    if (wr_nch == 2'd0 || 32'(wr_nch) > NUM_CH) nch_in = CH_W'(NUM_CH);
    else nch_in = CH_W'(wr_nch);
    for (int unsigned c = 0; c < NUM_CH; c++) lane_en[c] = (c < 32'(nch_q[rd_ptr]));
    issue     = (bank_st[rd_ptr] == B_DRAINING) && !iss_done &&
                ((32'(f_cnt) + 32'(v1) + 32'(v2)) < 32'd4);
    iss_last  = (gr_c == GR_W'(NUM_GR-1)) && (idx_c == ADDR_W'(DEPTH-1));
    pop       = (f_cnt != 3'd0) && rd_ready;
    head_last = fifo[f_rp][BEAT_W-1];
    wr_ram    = RAM_W'(wr_ptr) * RAM_W'(NSLOT) + RAM_W'(wr_slot);
    rd_base   = RAM_W'(rd_ptr) * RAM_W'(NSLOT) + RAM_W'(gr_c) * RAM_W'(NUM_CH);
  end

  // Drain address walk: idx fastest, then granule; stops after the final beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gr_c     <= '0;
      idx_c    <= '0;
      iss_done <= 1'b0;
    end else if (start_drain) begin
      gr_c     <= '0;
      idx_c    <= '0;
      iss_done <= 1'b0;
    end else if (issue) begin
      if (iss_last) begin
        iss_done <= 1'b1;
      end else if (idx_c == ADDR_W'(DEPTH-1)) begin
        idx_c <= '0;
        gr_c  <= gr_c + GR_W'(1);
      end else begin
        idx_c <= idx_c + ADDR_W'(1);
      end
    end
  end

  // RAM array: init zero sweep, fill writes, read-first drain with zero flush
  always_ff @(posedge clk) begin
    if (init_st == I_SWEEP) begin
      for (int unsigned r = 0; r < NRAM; r++) mem[RAM_W'(r)][init_addr] <= '0;
    end else begin
      if (wr_acc) mem[wr_ram][wr_pos] <= wr_data;
      if (issue) begin
        for (int unsigned c = 0; c < NUM_CH; c++)
          if (lane_en[c]) mem[rd_base + RAM_W'(c)][idx_c] <= '0;
      end
    end
    for (int unsigned c = 0; c < NUM_CH; c++)
      d1[c*DATA_W +: DATA_W] <= lane_en[c] ? mem[rd_base + RAM_W'(c)][idx_c] : '0;
    d2 <= d1;
  end

  // Beat tags travelling alongside the two-stage RAM read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0; v2 <= 1'b0; last1 <= 1'b0; last2 <= 1'b0;
      gr1 <= '0; gr2 <= '0; idx1 <= '0; idx2 <= '0;
    end else begin
      v1 <= issue; gr1 <= gr_c; idx1 <= idx_c; last1 <= iss_last;
      v2 <= v1;    gr2 <= gr1;  idx2 <= idx1;  last2 <= last1;
    end
  end

  // Four-entry output FIFO; issue credit guarantees it never overflows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) fifo[i] <= '0;
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (v2) begin
        fifo[f_wp] <= {last2, gr2, idx2, d2};
        f_wp       <= f_wp + 2'd1;
      end
      if (pop) f_rp <= f_rp + 2'd1;
      case ({v2, pop})
        2'b10:   f_cnt <= f_cnt + 3'd1;
        2'b01:   f_cnt <= f_cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // Sticky error flags for dropped or out-of-range write-side requests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_drop  <= 1'b0;
      err_range <= 1'b0;
    end else begin
      if ((wr_valid || wr_frame_end) && !wr_ready) err_drop <= 1'b1;
      if (wr_valid && range_bad) err_range <= 1'b1;
    end
  end

  assign rd_valid = (f_cnt != 3'd0);
  assign {rd_last, rd_gr, rd_idx, rd_data} = fifo[f_rp];

endmodule

// File: doc/granule_assembler_pp.md
Name: granule_assembler_pp

Overview:
- Parametrised, double-buffered successor to the single-frame granule/channel assembler.
- Collects position-addressed samples, keyed by (granule, channel) slot and reordered position, from the requantizer/reorder path into per-slot RAMs.
- Streams the completed frame to the stereo stage one granule-position at a time, with all channels side by side, under valid/ready backpressure.
- Two banks ping-pong, so frame N+1 fills while frame N drains. Drained locations are zero-flushed.

Parameters:
- DATA_W, 32: sample width.
- DEPTH, 576: positions per granule per channel.
- NUM_GR, 2: granules per frame.
- NUM_CH, 2: maximum channels.
- ADDR_W, $clog2(DEPTH): position width (derived).
- SLOT_W, $clog2(NUM_GR*NUM_CH): slot index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low.
- wr_valid  in  1  sample present.
- wr_ready  out  1  fill bank can accept samples.
- wr_slot  in  SLOT_W  gr*NUM_CH+ch.
- wr_pos  in  ADDR_W  reordered position.
- wr_data  in  DATA_W  sample.
- wr_frame_end  in  1  pulse: current fill bank complete.
- wr_nch  in  2  active channels (1..NUM_CH), sampled on wr_frame_end.
- rd_valid  out  1  output beat valid.
- rd_ready  in  1  downstream accepts beat.
- rd_data  out  NUM_CH*DATA_W  lane c = channel c.
- rd_gr  out  $clog2(NUM_GR)  granule of beat.
- rd_idx  out  ADDR_W  position of beat.
- rd_last  out  1  final beat of frame.
- init_busy  out  1  post-reset zero sweep in progress.
- err_drop  out  1  sticky: write dropped.
- err_range  out  1  sticky: wr_pos>=DEPTH or wr_slot>=NUM_GR*NUM_CH.

Behaviour:
- Storage: 2 banks x NUM_GR x NUM_CH single-port read-first RAMs, DEPTH x DATA_W each, read latency 2 (registered output).
- Reset (rst low, async) sets:
  - all outputs 0;
  - both bank states EMPTY;
  - wr_ptr=rd_ptr=0;
  - sticky errors cleared.
- After rst deasserts, INIT sweep: addresses 0..DEPTH-1, writing 0 to every RAM. This takes DEPTH cycles.
  - init_busy=1 and wr_ready=0 during the sweep.
  - Reset asserted mid-sweep restarts the sweep.
- Bank states: EMPTY -> FILLING (first accepted write, or wr_frame_end) -> FULL (wr_frame_end) -> DRAINING -> EMPTY (rd_last accepted).
- Write side:
  - wr_ready = !init_busy && bank[wr_ptr] in {EMPTY, FILLING}.
  - A write is accepted when wr_valid && wr_ready. It writes wr_data to bank[wr_ptr].slot[wr_slot][wr_pos] the same cycle.
  - Write attempted with wr_ready=0: dropped, err_drop<=1.
  - Out-of-range write: dropped, err_range<=1.
- wr_frame_end while wr_ready=1:
  - latches wr_nch into the bank's nch register (0 or >NUM_CH is clamped to NUM_CH);
  - bank -> FULL, wr_ptr toggles;
  - a wr_valid in the same cycle is written first.
  - wr_frame_end while wr_ready=0 is ignored and sets err_drop.
  - An empty frame (no writes) is legal and drains as all zeros.
- Read side:
  - When bank[rd_ptr]==FULL it becomes DRAINING.
  - An address counter walks gr 0..NUM_GR-1, then idx 0..DEPTH-1 within each gr.
  - Each issued address reads all NUM_CH RAMs of that gr and simultaneously writes 0 (flush) to the same address.
  - Lanes c>=nch are not read or flushed and are driven 0 on rd_data.
- Output path:
  - 2-cycle RAM latency feeds a 4-entry output FIFO.
  - A read is issued only if (FIFO occupancy + in-flight reads) < 4, so no beat is ever lost under backpressure.
  - rd_valid = FIFO non-empty. A beat transfers on rd_valid && rd_ready.
  - rd_data/gr/idx/last hold stable while rd_valid && !rd_ready.
- rd_last=1 on beat (gr=NUM_GR-1, idx=DEPTH-1).
  - On its transfer, bank -> EMPTY and rd_ptr toggles.
  - The next bank, if FULL, starts issuing the next cycle.
- Throughput: 1 beat/cycle with rd_ready held 1. First rd_valid occurs 3 cycles after the bank enters DRAINING.
- Simultaneous: fill and drain always target different banks, so there are no port conflicts. A bank emptying in the same cycle as wr_frame_end of the other bank is legal.
- Counter arithmetic is unsigned. idx wraps DEPTH-1 -> 0 with gr+1; no wrap past the final gr.

Test Plan:
- Init sweep: release rst, then poll init_busy -> 1 for exactly 576 cycles, then wr_ready=1. Drain an empty frame (wr_frame_end only) -> 1152 beats, all rd_data=0, rd_last on beat 1152.
- Basic frame, wr_nch=2: write slot s, pos p, value {s,p} for all s, p, then wr_frame_end. Required beats:
  - beat k<576: gr=0, idx=k, lanes {0,k},{1,k};
  - beat k>=576: gr=1, lanes {2,k-576},{3,k-576};
  - rd_last on beat 1152.
- Ping-pong plus flush: frame A writes pos 0..9 only, frame B writes pos 5 only, B is filled while A drains. Required:
  - A drains with 0 beyond pos 9;
  - B drains all 0 except pos 5;
  - frame C in bank A then reads 0 at A's old positions.
- Backpressure: rd_ready random (≈30% duty) -> identical beat sequence to the rd_ready=1 case, no missing or duplicated idx, data stable while stalled.
- Mono and errors:
  - wr_nch=1 -> lane 1 always 0.
  - Writing while both banks are FULL -> err_drop=1, data unaffected.
  - wr_pos=600 -> err_range=1, write dropped.
- Reset mid-drain at beat 300 -> rd_valid=0 immediately, init sweep repeats, subsequent frame drains correctly with zeros at unwritten positions.
